// File: rtl/freq_mon_pkg.sv
// Shared types and default constants for the divided-clock frequency monitor.
// Holds the FSM state enum, the 8-bit period type and its saturating increment.
package freq_mon_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } state_t;

    localparam int unsigned DEF_WINDOW  = 1024;
    localparam int unsigned DEF_PER_MIN = 4;
    localparam int unsigned DEF_PER_MAX = 5;
    localparam int unsigned DEF_TIMEOUT = 64;

    localparam int unsigned PERIOD_W = 8;
    typedef logic [PERIOD_W-1:0] period_t;
    localparam period_t PERIOD_SAT = '1;

    function automatic period_t period_inc(input period_t p);
        return (p == PERIOD_SAT) ? p : p + period_t'(1);
    endfunction

endpackage

// File: rtl/freq_monitor_if.sv
// Control and result bundle between the frequency monitor and its consumer.
// valid is a one-cycle pulse qualifying edge_cnt; there is no ready, so the consumer must capture on the pulse.
interface freq_monitor_if #(
    parameter int CNT_W = 32
);
    import freq_mon_pkg::*;

    logic             en;
    logic             div_in;
    logic             err_clr;
    logic [CNT_W-1:0] edge_cnt;
    logic             valid;
    period_t          period_last;
    logic             period_err;
    logic             stuck;
    logic [CNT_W-1:0] err_cnt;
    logic             busy;

    modport master (
        output en, div_in, err_clr,
        input  edge_cnt, valid, period_last, period_err, stuck, err_cnt, busy
    );

    modport slave (
        input  en, div_in, err_clr,
        output edge_cnt, valid, period_last, period_err, stuck, err_cnt, busy
    );

endinterface

// File: rtl/freq_monitor_edge_sync.sv
// Synchronizer chain plus rising-edge detector for an asynchronous level input.
// rise is a one-cycle pulse derived from the last synchronizer stage.
module edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/freq_monitor.sv
// Single-clock checker for a fractional divider output: counts rising edges per window,
// measures every period against [PER_MIN, PER_MAX] and flags a stuck divider.
module freq_monitor
    import freq_mon_pkg::*;
#(
    parameter int unsigned WINDOW      = DEF_WINDOW,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned PER_MIN     = DEF_PER_MIN,
    parameter int unsigned PER_MAX     = DEF_PER_MAX,
    parameter int unsigned TIMEOUT     = DEF_TIMEOUT,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    freq_monitor_if.slave  mon,
    output state_t         dbg_state
);

    localparam int unsigned      WIN_W       = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST    = WIN_W'(WINDOW - 1);
    localparam period_t          PMIN        = period_t'(PER_MIN);
    localparam period_t          PMAX        = period_t'(PER_MAX);
    localparam period_t          TIMEOUT_PRE = period_t'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_SAT     = '1;

    state_t           state_q;
    state_t           state_d;
    logic             busy;
    logic             measuring;
    logic             rise;

    logic [WIN_W-1:0] win_cnt_q;
    logic [CNT_W-1:0] acc_q;
    period_t          per_cnt_q;

    logic [CNT_W-1:0] edge_cnt_q;
    logic             valid_q;
    period_t          period_last_q;
    logic             period_err_q;
    logic             stuck_q;
    logic [CNT_W-1:0] err_cnt_q;

    logic             win_end;
    logic             meas_rise;
    period_t          period;
    logic             bad;
    logic             stuck_set;

    edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (mon.div_in),
        .rise  (rise)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Dropping en abandons a window at once; a window ending in that same cycle is still reported.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (mon.en) state_d = ARM;
            ARM:     if (!mon.en) state_d = IDLE;
                     else if (rise) state_d = MEASURE;
            MEASURE: if (!mon.en) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy      = 1'b0;
        measuring = 1'b0;
        dbg_state = state_q;
        unique case (state_q)
            IDLE:    ;
            ARM:     busy = 1'b1;
            MEASURE: begin
                busy      = 1'b1;
                measuring = 1'b1;
            end
            default: ;
        endcase
    end

    assign win_end   = measuring && (win_cnt_q == WIN_LAST);
    assign meas_rise = measuring && rise;
    assign period    = period_inc(per_cnt_q);
    assign bad       = meas_rise && ((period < PMIN) || (period > PMAX));
    // Fire on the cycle per_cnt steps onto TIMEOUT so the flag and the count line up.
    assign stuck_set = measuring && !rise && (per_cnt_q == TIMEOUT_PRE);

    // Outside MEASURE the counters sit at zero, so the aligning edge in ARM starts a clean window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt_q <= '0;
            acc_q     <= '0;
            per_cnt_q <= '0;
        end else if (!measuring) begin
            win_cnt_q <= '0;
            acc_q     <= '0;
            per_cnt_q <= '0;
        end else begin
            win_cnt_q <= win_end ? '0 : win_cnt_q + WIN_W'(1);
            acc_q     <= win_end ? '0 : acc_q + CNT_W'(rise);
            per_cnt_q <= rise ? '0 : period_inc(per_cnt_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_cnt_q    <= '0;
            valid_q       <= 1'b0;
            period_last_q <= '0;
        end else begin
            valid_q <= win_end;
            if (win_end) begin
                edge_cnt_q <= acc_q + CNT_W'(rise);
            end
            if (meas_rise) begin
                period_last_q <= period;
            end
        end
    end

    // A new error in the same cycle as err_clr survives the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_err_q <= 1'b0;
            stuck_q      <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            if (bad) begin
                period_err_q <= 1'b1;
            end else if (mon.err_clr) begin
                period_err_q <= 1'b0;
            end

            if (stuck_set) begin
                stuck_q <= 1'b1;
            end else if (mon.err_clr) begin
                stuck_q <= 1'b0;
            end

            if (mon.err_clr) begin
                err_cnt_q <= bad ? CNT_W'(1) : '0;
            end else if (bad && (err_cnt_q != CNT_SAT)) begin
                err_cnt_q <= err_cnt_q + CNT_W'(1);
            end
        end
    end

    assign mon.edge_cnt    = edge_cnt_q;
    assign mon.valid       = valid_q;
    assign mon.period_last = period_last_q;
    assign mon.period_err  = period_err_q;
    assign mon.stuck       = stuck_q;
    assign mon.err_cnt     = err_cnt_q;
    assign mon.busy        = busy;

endmodule

// File: tb/tb_freq_monitor.sv
// Directed bench for freq_monitor: two instances (WINDOW 1024 and 410) share div_in/err_clr;
// window results go through per-instance expected queues checked by valid-driven monitors.
module tb_freq_monitor;
  import freq_mon_pkg::*;

  localparam int CNT_W = 32;
  localparam int WIN_A = 1024;
  localparam int WIN_B = 410;

  typedef struct packed {
    logic [CNT_W-1:0] edge_cnt;
    logic             period_err;
    logic [CNT_W-1:0] err_cnt;
    logic             stuck;
  } exp_t;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  logic   div_in = 1'b0;
  logic   err_clr = 1'b0;
  logic   en_a = 1'b0;
  logic   en_b = 1'b0;
  state_t dbg_a;
  state_t dbg_b;

  int   n_tests = 0;
  int   n_fail = 0;
  exp_t exp_a[$];
  exp_t exp_b[$];
  exp_t e_a;
  exp_t e_b;
  logic prev_valid_a = 1'b0;
  logic prev_valid_b = 1'b0;
  int   lat;
  bit   seen;
  logic pl_ok;

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  freq_monitor_if #(.CNT_W(CNT_W)) if_a ();
  freq_monitor_if #(.CNT_W(CNT_W)) if_b ();

  assign if_a.en      = en_a;
  assign if_a.div_in  = div_in;
  assign if_a.err_clr = err_clr;
  assign if_b.en      = en_b;
  assign if_b.div_in  = div_in;
  assign if_b.err_clr = err_clr;

  freq_monitor #(.WINDOW(WIN_A), .CNT_W(CNT_W)) u_dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .mon       (if_a.slave),
    .dbg_state (dbg_a)
  );

  freq_monitor #(.WINDOW(WIN_B), .CNT_W(CNT_W)) u_dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .mon       (if_b.slave),
    .dbg_state (dbg_b)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_periods(input int p, input int n);
    for (int i = 0; i < n; i++) begin
      div_in = 1'b1;
      repeat (2) @(negedge clk);
      div_in = 1'b0;
      repeat (p - 2) @(negedge clk);
    end
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
  endtask

  function automatic exp_t mk_exp(input int ec, input logic pe, input int cnt, input logic st);
    exp_t e;
    e.edge_cnt   = CNT_W'(ec);
    e.period_err = pe;
    e.err_cnt    = CNT_W'(cnt);
    e.stuck      = st;
    return e;
  endfunction

  task automatic compare_win(input string tag, input exp_t e, input logic [CNT_W-1:0] ec,
                             input logic pe, input logic [CNT_W-1:0] cnt, input logic st);
    check({tag, "_edge_cnt"}, 64'(ec), 64'(e.edge_cnt));
    check({tag, "_period_err"}, 64'(pe), 64'(e.period_err));
    check({tag, "_err_cnt"}, 64'(cnt), 64'(e.err_cnt));
    check({tag, "_stuck"}, 64'(st), 64'(e.stuck));
  endtask

  // scoreboard monitors: one expected entry per valid pulse
  always @(negedge clk) begin
    if (if_a.valid) begin
      check("a_valid_spacing", 64'(prev_valid_a), 64'd0);
      if (exp_a.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL a_unexpected_valid: got edge_cnt %0d expected no valid", if_a.edge_cnt);
      end else begin
        e_a = exp_a.pop_front();
        compare_win("a_win", e_a, if_a.edge_cnt, if_a.period_err, if_a.err_cnt, if_a.stuck);
      end
    end
    prev_valid_a = if_a.valid;
  end

  always @(negedge clk) begin
    if (if_b.valid) begin
      check("b_valid_spacing", 64'(prev_valid_b), 64'd0);
      if (exp_b.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL b_unexpected_valid: got edge_cnt %0d expected no valid", if_b.edge_cnt);
      end else begin
        e_b = exp_b.pop_front();
        compare_win("b_win", e_b, if_b.edge_cnt, if_b.period_err, if_b.err_cnt, if_b.stuck);
      end
    end
    prev_valid_b = if_b.valid;
  end

  initial begin
    // reset values
    idle(3);
    check("rst_edge_cnt", 64'(if_a.edge_cnt), 0);
    check("rst_valid", 64'(if_a.valid), 0);
    check("rst_period_last", 64'(if_a.period_last), 0);
    check("rst_period_err", 64'(if_a.period_err), 0);
    check("rst_stuck", 64'(if_a.stuck), 0);
    check("rst_err_cnt", 64'(if_a.err_cnt), 0);
    check("rst_busy", 64'(if_a.busy), 0);
    check("rst_b_busy", 64'(if_b.busy), 0);
    rst_n = 1'b1;
    idle(2);

    // square wave of period 4: two full windows of 256 edges
    en_a = 1'b1;
    idle(3);
    check("t1_busy_arm", 64'(if_a.busy), 1);
    check("t1_state_arm", 64'(dbg_a), 64'(ARM));
    exp_a.push_back(mk_exp(256, 1'b0, 0, 1'b0));
    exp_a.push_back(mk_exp(256, 1'b0, 0, 1'b0));
    send_periods(4, 520);
    check("t1_period_last", 64'(if_a.period_last), 4);
    check("t1_period_err", 64'(if_a.period_err), 0);
    check("t1_err_cnt", 64'(if_a.err_cnt), 0);
    en_a = 1'b0;
    idle(2);
    check("t1_state_idle", 64'(dbg_a), 64'(IDLE));
    check("t1_edge_cnt_hold", 64'(if_a.edge_cnt), 256);

    // alternating 4x4 / 5x5 pattern: 90 edges per 410-cycle window
    en_b = 1'b1;
    idle(3);
    exp_b.push_back(mk_exp(90, 1'b0, 0, 1'b0));
    exp_b.push_back(mk_exp(90, 1'b0, 0, 1'b0));
    repeat (21) begin
      send_periods(4, 4);
      send_periods(5, 5);
    end
    pl_ok = (if_b.period_last == 8'd4) || (if_b.period_last == 8'd5);
    check("t2_period_last_legal", 64'(pl_ok), 1);
    check("t2_period_err", 64'(if_b.period_err), 0);
    en_b = 1'b0;
    idle(2);

    // injected period of 6, clear, then clear colliding with a new bad period
    en_a = 1'b1;
    idle(3);
    send_periods(4, 5);
    send_periods(6, 1);
    send_periods(4, 1);
    check("t3_period_last_6", 64'(if_a.period_last), 6);
    check("t3_period_err_set", 64'(if_a.period_err), 1);
    check("t3_err_cnt_1", 64'(if_a.err_cnt), 1);
    fork
      send_periods(4, 8);
      begin
        idle(5);
        pulse_clr();
      end
    join
    check("t3_clr_period_err", 64'(if_a.period_err), 0);
    check("t3_clr_err_cnt", 64'(if_a.err_cnt), 0);
    check("t3_period_last_4", 64'(if_a.period_last), 4);
    fork
      begin
        send_periods(6, 1);
        send_periods(4, 3);
      end
      begin
        idle(8);
        pulse_clr();
      end
    join
    check("t3_collide_period_err", 64'(if_a.period_err), 1);
    check("t3_collide_err_cnt", 64'(if_a.err_cnt), 1);
    en_a = 1'b0;
    idle(2);
    check("t3_sticky_over_en", 64'(if_a.period_err), 1);
    pulse_clr();
    check("t3_final_clr_err", 64'(if_a.period_err), 0);
    check("t3_final_clr_cnt", 64'(if_a.err_cnt), 0);

    // stuck: one aligning edge, then div_in held low
    en_a = 1'b1;
    idle(3);
    exp_a.push_back(mk_exp(0, 1'b0, 0, 1'b1));
    div_in = 1'b1;
    idle(2);
    div_in = 1'b0;
    idle(64);
    check("t4_stuck_before", 64'(if_a.stuck), 0);
    idle(1);
    check("t4_stuck_at_timeout", 64'(if_a.stuck), 1);
    idle(1000);
    en_a = 1'b0;
    idle(2);
    check("t4_no_period_err", 64'(if_a.period_err), 0);
    pulse_clr();
    check("t4_stuck_cleared", 64'(if_a.stuck), 0);

    // en dropped around win_cnt 500 of the second window
    en_a = 1'b1;
    idle(3);
    exp_a.push_back(mk_exp(256, 1'b0, 0, 1'b0));
    send_periods(4, 382);
    en_a = 1'b0;
    idle(1);
    check("t5_state_idle", 64'(dbg_a), 64'(IDLE));
    check("t5_busy_low", 64'(if_a.busy), 0);
    idle(20);
    check("t5_edge_cnt_hold", 64'(if_a.edge_cnt), 256);
    en_a = 1'b1;
    idle(2);
    check("t5_rearm_state", 64'(dbg_a), 64'(ARM));
    div_in = 1'b1;
    idle(2);
    div_in = 1'b0;
    idle(1);
    check("t5_rearm_measure", 64'(dbg_a), 64'(MEASURE));
    en_a = 1'b0;
    idle(2);

    // reset mid-window with period_err set
    en_a = 1'b1;
    idle(3);
    send_periods(4, 3);
    send_periods(6, 1);
    send_periods(4, 2);
    check("t6_pre_period_err", 64'(if_a.period_err), 1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_edge_cnt", 64'(if_a.edge_cnt), 0);
    check("t6_rst_valid", 64'(if_a.valid), 0);
    check("t6_rst_period_last", 64'(if_a.period_last), 0);
    check("t6_rst_period_err", 64'(if_a.period_err), 0);
    check("t6_rst_err_cnt", 64'(if_a.err_cnt), 0);
    check("t6_rst_busy", 64'(if_a.busy), 0);
    check("t6_rst_state", 64'(dbg_a), 64'(IDLE));
    idle(3);
    rst_n = 1'b1;
    idle(3);
    exp_a.push_back(mk_exp(256, 1'b0, 0, 1'b0));
    fork
      send_periods(4, 260);
      begin
        lat = 0;
        seen = 1'b0;
        while (!seen && lat < 1200) begin
          @(negedge clk);
          lat++;
          if (if_a.valid) seen = 1'b1;
        end
        check("t6_first_valid_latency", 64'(lat), 64'(WIN_A + 3));
      end
    join
    en_a = 1'b0;
    idle(2);

    // final report
    check("a_queue_drained", 64'(exp_a.size()), 0);
    check("b_queue_drained", 64'(exp_b.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
